// File: rtl/cmd_load_tri.sv
// cmd_load_tri: buffers one 32-byte CMD_LOAD_TRI payload and, on commit,
// writes three vertex records then one edge record into the triangle store.
module cmd_load_tri #(
    parameter int DEPTH     = 1024,
    parameter int DW_VERTEX = 64,
    parameter int DW_EDGE   = 48,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 start_pulse,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    input  logic                 commit_pulse,
    input  logic                 abort_pulse,
    output logic [AW-1:0]        ADDR_VERTEX,
    output logic [DW_VERTEX-1:0] DIN_VERTEX,
    output logic                 WE_VERTEX,
    output logic [AW-1:0]        ADDR_EDGE,
    output logic [DW_EDGE-1:0]   DIN_EDGE,
    output logic                 WE_EDGE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_WAIT,
        S_WR_V0,
        S_WR_V1,
        S_WR_V2,
        S_WR_E
    } state_t;

    localparam logic [16:0] LIM = 17'(DEPTH);

    state_t         state;
    logic [255:0]   pay;
    logic [4:0]     cnt;

    logic [15:0]    ea;
    logic [15:0]    a0;
    logic [15:0]    a1;
    logic [15:0]    a2;
    logic [63:0]    v0;
    logic [63:0]    v1;
    logic [63:0]    v2;
    logic           addr_ok;
    logic           xfer;

    // Bytes shift in MSB first, so the first byte ends up at the top.
    assign ea = pay[255:240];
    assign a0 = pay[239:224];
    assign v0 = pay[223:160];
    assign a1 = pay[159:144];
    assign v1 = pay[143:80];
    assign a2 = pay[79:64];
    assign v2 = pay[63:0];

    assign addr_ok = ({1'b0, ea} < LIM) && ({1'b0, a0} < LIM) &&
                     ({1'b0, a1} < LIM) && ({1'b0, a2} < LIM);

    assign xfer = byte_valid && byte_ready;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pay         <= '0;
            cnt         <= '0;
            byte_ready  <= 1'b0;
            ADDR_VERTEX <= '0;
            DIN_VERTEX  <= '0;
            WE_VERTEX   <= 1'b0;
            ADDR_EDGE   <= '0;
            DIN_EDGE    <= '0;
            WE_EDGE     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            WE_VERTEX <= 1'b0;
            WE_EDGE   <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        state      <= S_RX;
                        BUSY       <= 1'b1;
                        byte_ready <= 1'b1;
                        cnt        <= '0;
                        pay        <= '0;
                    end
                end
                S_RX: begin
                    if (abort_pulse) begin
                        state      <= S_IDLE;
                        BUSY       <= 1'b0;
                        byte_ready <= 1'b0;
                    end else if (xfer) begin
                        pay <= {pay[247:0], byte_data};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state      <= S_WAIT;
                            byte_ready <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort_pulse) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else if (commit_pulse) begin
                        if (!addr_ok) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                            ERR   <= 1'b1;
                        end else begin
                            state       <= S_WR_V0;
                            WE_VERTEX   <= 1'b1;
                            ADDR_VERTEX <= a0[AW-1:0];
                            DIN_VERTEX  <= v0;
                        end
                    end
                end
                S_WR_V0: begin
                    state       <= S_WR_V1;
                    WE_VERTEX   <= 1'b1;
                    ADDR_VERTEX <= a1[AW-1:0];
                    DIN_VERTEX  <= v1;
                end
                S_WR_V1: begin
                    state       <= S_WR_V2;
                    WE_VERTEX   <= 1'b1;
                    ADDR_VERTEX <= a2[AW-1:0];
                    DIN_VERTEX  <= v2;
                end
                S_WR_V2: begin
                    state     <= S_WR_E;
                    WE_EDGE   <= 1'b1;
                    ADDR_EDGE <= ea[AW-1:0];
                    DIN_EDGE  <= {a2, a1, a0};
                end
                S_WR_E: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
